// File: rtl/mfp_ahb_master.sv
// -----------------------------------------------------------------------------
// mfp_ahb_master
//   AHB-lite initiator for the MFP SoC. Hardware engines hand it word
//   commands (single beat or INCR burst of up to MAX_BEATS beats). It streams
//   write beats in over wr_*, streams read beats out over rd_*, and pulses
//   done (with err) once the command has finished on the bus. Address and
//   data phases are pipelined. The block honours HREADY wait states and the
//   two-cycle HRESP ERROR response.
//
// Ports
//   HCLK, HRESET                      clock; synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_addr, cmd_write, cmd_len      start address (word aligned), direction,
//                                     beats-1
//   wr_data/wr_valid/wr_ready         write beat stream
//   rd_data/rd_valid                  read beat stream (no backpressure)
//   done/err                          end-of-command pulse and abort flag
//   HADDR..HWDATA, HRDATA/HREADY/HRESP  AHB-lite master interface
// -----------------------------------------------------------------------------
module mfp_ahb_master #(
  parameter int         MAX_BEATS = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  localparam int        LEN_W     = $clog2(MAX_BEATS)
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic             cmd_write,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [3:0]       HPROT,
  output logic             HMASTLOCK,
  output logic [31:0]      HWDATA,
  input  logic [31:0]      HRDATA,
  input  logic             HREADY,
  input  logic             HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA_LAST,
    S_ERR1
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] beats_left;     // address phases still to issue, minus one
  logic             first_beat;
  logic             dphase_vld_p1;  // a data phase of ours is on the bus
  logic             dphase_wr_p1;   // direction of that data phase

  logic beat_active;
  logic cancel;
  logic addr_accept;
  logic dphase_done;
  logic dphase_err;
  logic addr_lsb_unused;

  // The address is always word aligned; the low bits are simply dropped.
  assign addr_lsb_unused = ^cmd_addr[1:0];

  assign HSIZE     = 3'b010;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign cmd_ready = (state == S_IDLE);

  // A write beat can only go on the bus once its data is available.
  assign beat_active = (state == S_ADDR) && (!HWRITE || wr_valid);

  // First cycle of an ERROR response: the address phase presented alongside
  // it must be withdrawn immediately, so this path is combinational.
  assign cancel      = dphase_vld_p1 && HRESP && !HREADY;
  assign addr_accept = beat_active && HREADY && !cancel;
  assign dphase_done = dphase_vld_p1 && HREADY && !HRESP;
  assign dphase_err  = dphase_vld_p1 && HREADY && HRESP;

  assign wr_ready = addr_accept && HWRITE;

  // Transfer type. A later beat landing on a 1KB boundary restarts as
  // NONSEQ because INCR bursts may not cross that boundary on AHB.
  always_comb begin
    HTRANS = TR_IDLE;
    if ((state == S_ADDR) && !cancel) begin
      if (beat_active) begin
        HTRANS = (first_beat || (HADDR[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
      end else begin
        HTRANS = first_beat ? TR_IDLE : TR_BUSY;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= S_IDLE;
      beats_left    <= '0;
      first_beat    <= 1'b0;
      dphase_vld_p1 <= 1'b0;
      dphase_wr_p1  <= 1'b0;
      HADDR         <= '0;
      HWRITE        <= 1'b0;
      HBURST        <= BURST_SINGLE;
      HWDATA        <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;

      // ---- data phase boundary: capture read beat / load write beat ----
      if (dphase_done && !dphase_wr_p1) begin
        rd_data  <= HRDATA;
        rd_valid <= 1'b1;
      end
      if (wr_ready) begin
        HWDATA <= wr_data;
      end

      // An accepted address phase becomes the pending data phase; otherwise
      // the pending one retires on completion or at the end of an error.
      if (addr_accept) begin
        dphase_vld_p1 <= 1'b1;
        dphase_wr_p1  <= HWRITE;
      end else if (dphase_done || dphase_err) begin
        dphase_vld_p1 <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            HADDR      <= {cmd_addr[31:2], 2'b00};
            HWRITE     <= cmd_write;
            HBURST     <= (cmd_len == '0) ? BURST_SINGLE : BURST_INCR;
            beats_left <= cmd_len;
            first_beat <= 1'b1;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (cancel) begin
            state <= S_ERR1;
          end else if (addr_accept) begin
            if (beats_left == '0) begin
              state <= S_DATA_LAST;
            end else begin
              HADDR      <= HADDR + 32'd4;
              beats_left <= beats_left - 1'b1;
              first_beat <= 1'b0;
            end
          end
        end
        S_DATA_LAST: begin
          if (cancel) begin
            state <= S_ERR1;
          end else if (dphase_done) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ERR1: begin
          if (dphase_err) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
